// File: rtl/mem_stage.sv
// mem_stage: memory stage between execute and writeback.
// ALU results pass straight through. Loads and stores run a req/gnt/rvalid
// handshake with data memory, and the upstream pipe is held meanwhile.
// An access that stays incomplete for TIMEOUT_CYC cycles is aborted with bus_err6.
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses are rejected. When it is undefined, the low address bits
// are forced to the access size.
module mem_stage #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] alu_res5,
    input  logic [4:0]  rd5,
    input  logic        we5,
    input  logic        fn5,
    input  logic        mem_rd5,
    input  logic        mem_wr5,
    input  logic [2:0]  mem_fn5,
    input  logic [31:0] st_data5,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] wb_data6,
    output logic [4:0]  rd6,
    output logic        we6,
    output logic        bus_err6,
    output logic        misalign6
);
    localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {ACCESS = 1'b0, WAIT_RSP = 1'b1} state_t;

    // Input register R
    logic [31:0] alu_reg;
    logic [4:0]  rd_reg;
    logic        we_reg;
    logic        fn_reg;
    logic        mrd_reg;
    logic        mwr_reg;
    logic [2:0]  mfn_reg;
    logic [31:0] st_reg;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;

    logic        mem_op, is_store, is_byte, is_half, is_word;
    logic [1:0]  off;
    logic        misalign, timeout, retire;
    logic [3:0]  be_raw;
    logic [31:0] rdata_shift, load_data;
    logic [31:0] wb_next;
    logic [4:0]  rd_next;
    logic        we_next, berr_next, mis_next;

    // Decode of the op held in R. Both mem_rd and mem_wr set means a store.
    assign mem_op   = fn_reg & (mrd_reg | mwr_reg);
    assign is_store = mwr_reg;
    assign is_word  = mfn_reg[1];
    assign is_half  = (mfn_reg[1:0] == 2'b01);
    assign is_byte  = (mfn_reg[1:0] == 2'b00);
    assign off      = is_word ? 2'b00 : (is_half ? {alu_reg[1], 1'b0} : alu_reg[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = mem_op & ((is_half & alu_reg[0]) | (is_word & (alu_reg[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // Timeout aborts only accesses that actually reach the bus.
    assign timeout = mem_op & ~misalign & (cnt_reg == CNT_W'(TIMEOUT_CYC));

    assign be_raw     = is_word ? 4'b1111 : (is_half ? (4'b0011 << off) : (4'b0001 << off));
    assign dmem_be    = mem_op ? be_raw : 4'b0000;
    assign dmem_we    = mem_op & is_store;
    assign dmem_addr  = {alu_reg[31:2], 2'b00};

    // Store data replicated into every byte lane at the access size
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign dmem_wdata[gi*8 +: 8] = is_word ? st_reg[gi*8 +: 8] :
                                           (is_half ? st_reg[(gi % 2)*8 +: 8] : st_reg[7:0]);
        end
    endgenerate

    // Load formatting: shift the addressed lane down, then sign or zero extend
    assign rdata_shift = dmem_rdata >> {off, 3'b000};
    assign load_data = is_byte ? {{24{~mfn_reg[2] & rdata_shift[7]}}, rdata_shift[7:0]} :
                       is_half ? {{16{~mfn_reg[2] & rdata_shift[15]}}, rdata_shift[15:0]} :
                                 dmem_rdata;

    // FSM state register
    always_ff @(posedge clk) begin
        if (nrst) state_reg <= ACCESS;
        else      state_reg <= state_next;
    end

    // FSM next state: a granted load waits for its response; a timeout or response ends the wait
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCESS:   if (dmem_req & dmem_gnt & ~is_store) state_next = WAIT_RSP;
            WAIT_RSP: if (timeout | dmem_rvalid)           state_next = ACCESS;
            default:  state_next = ACCESS;
        endcase
    end

    // FSM outputs: request, retire condition and upstream stall
    always_comb begin
        dmem_req = (state_reg == ACCESS) & mem_op & ~misalign & ~timeout;
        retire   = ~mem_op | misalign | timeout
                 | (dmem_req & dmem_gnt & is_store)
                 | ((state_reg == WAIT_RSP) & dmem_rvalid);
        stall    = mem_op & ~retire;
    end

    // Input register: sample execute outputs whenever the stage is not holding
    always_ff @(posedge clk) begin
        if (nrst) begin
            alu_reg <= '0;
            rd_reg  <= '0;
            we_reg  <= 1'b0;
            fn_reg  <= 1'b0;
            mrd_reg <= 1'b0;
            mwr_reg <= 1'b0;
            mfn_reg <= '0;
            st_reg  <= '0;
        end else if (!stall) begin
            alu_reg <= alu_res5;
            rd_reg  <= rd5;
            we_reg  <= we5;
            fn_reg  <= fn5;
            mrd_reg <= mem_rd5;
            mwr_reg <= mem_wr5;
            mfn_reg <= mem_fn5;
            st_reg  <= st_data5;
        end
    end

    // Timeout counter: counts stalled cycles and clears whenever R advances
    always_ff @(posedge clk) begin
        if (nrst)       cnt_reg <= '0;
        else if (stall) cnt_reg <= cnt_reg + 1'b1;
        else            cnt_reg <= '0;
    end

    // Writeback values for the retiring op; any non-retire cycle is a bubble
    always_comb begin
        wb_next   = wb_data6;
        rd_next   = rd6;
        we_next   = 1'b0;
        berr_next = 1'b0;
        mis_next  = 1'b0;
        if (retire && fn_reg) begin
            rd_next = rd_reg;
            wb_next = alu_reg;
            if (!mem_op) begin
                we_next = we_reg;
            end else if (misalign) begin
                mis_next = 1'b1;
            end else if (timeout) begin
                berr_next = 1'b1;
            end else if (!is_store) begin
                wb_next = load_data;
                we_next = we_reg;
            end
        end
    end

    // Output register toward writeback
    always_ff @(posedge clk) begin
        if (nrst) begin
            wb_data6  <= '0;
            rd6       <= '0;
            we6       <= 1'b0;
            bus_err6  <= 1'b0;
            misalign6 <= 1'b0;
        end else begin
            wb_data6  <= wb_next;
            rd6       <= rd_next;
            we6       <= we_next;
            bus_err6  <= berr_next;
            misalign6 <= mis_next;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed plus random checks of mem_stage against a
// behavioural model. The bench also acts as the data memory and controls
// the gnt and rvalid delays.
module tb_mem_stage;
    localparam int TO = 6;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] alu_res5;
    logic [4:0]  rd5;
    logic        we5, fn5, mem_rd5, mem_wr5;
    logic [2:0]  mem_fn5;
    logic [31:0] st_data5;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] wb_data6;
    logic [4:0]  rd6;
    logic        we6, bus_err6, misalign6;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the held writeback fields
    logic [31:0] exp_wb;
    logic [4:0]  exp_rd;
    logic        exp_known;

    // Random op fields
    logic [31:0] ra, rst_d, rdat;
    logic [4:0]  rr;
    logic        rw, rf, rmr, rmw, rnr;
    logic [2:0]  rmf;
    int          rgd, rrl;

    mem_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .nrst(nrst),
        .alu_res5(alu_res5), .rd5(rd5), .we5(we5), .fn5(fn5),
        .mem_rd5(mem_rd5), .mem_wr5(mem_wr5), .mem_fn5(mem_fn5), .st_data5(st_data5),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_data6(wb_data6), .rd6(rd6), .we6(we6), .bus_err6(bus_err6), .misalign6(misalign6)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Upstream garbage with fn5=0; it must never be sampled while stalled
    task automatic drive_bubble();
        alu_res5 = $urandom;
        rd5      = 5'($urandom);
        we5      = 1'($urandom);
        fn5      = 1'b0;
        mem_rd5  = 1'($urandom);
        mem_wr5  = 1'($urandom);
        mem_fn5  = 3'($urandom);
        st_data5 = $urandom;
    endtask

    // Issue one op and act as memory: gnt is sent in R-cycle gd+1, and rvalid
    // follows rdl cycles later. noresp withholds rvalid.
    task automatic run_op(input logic [31:0] a, input logic [4:0] r, input logic w, input logic f,
                          input logic mr, input logic mw, input logic [2:0] mf, input logic [31:0] st,
                          input int gd, input int rdl, input logic [31:0] rdata_v, input logic noresp);
        logic        memop, store, uns, mis, berr, exp_req, exp_we;
        int          bytes, off, ret;
        logic [31:0] mask, ldv, wd, bev;
        memop = f & (mr | mw);
        store = mw;
        uns   = mf[2];
        bytes = mf[1] ? 4 : (mf[0] ? 2 : 1);
        off   = (bytes == 1) ? int'(a % 4) : ((bytes == 2) ? (int'(a % 4) / 2) * 2 : 0);
        mis   = TRAP && memop && ((bytes == 2 && (a % 2) != 0) || (bytes == 4 && (a % 4) != 0));
        berr  = 1'b0;
        if (!memop || mis) ret = 1;
        else if (store) begin
            if (gd + 1 <= TO) ret = gd + 1;
            else begin ret = TO + 1; berr = 1'b1; end
        end else if (!noresp && gd + 1 + rdl <= TO) ret = gd + 1 + rdl;
        else begin ret = TO + 1; berr = 1'b1; end
        bev = ((32'd1 << bytes) - 1) << off;
        for (int i = 0; i < 4; i++) wd[i*8 +: 8] = st[(i % bytes)*8 +: 8];
        mask = (bytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes)) - 1);
        ldv  = (rdata_v >> (8 * off)) & mask;
        if (!uns && bytes < 4 && ldv[8*bytes-1]) ldv = ldv | ~mask;
        if (!memop)                      exp_we = w & f;
        else if (!mis && !berr && !store) exp_we = w;
        else                             exp_we = 1'b0;

        alu_res5 = a; rd5 = r; we5 = w; fn5 = f;
        mem_rd5 = mr; mem_wr5 = mw; mem_fn5 = mf; st_data5 = st;
        @(posedge clk); #1;
        for (int c = 1; c <= ret; c++) begin
            drive_bubble();
            dmem_gnt    = memop && !mis && (c == gd + 1);
            dmem_rvalid = memop && !store && !mis && !noresp && (c == gd + 1 + rdl) && (c <= TO);
            dmem_rdata  = dmem_rvalid ? rdata_v : $urandom;
            @(negedge clk);
            exp_req = memop && !mis && (c <= gd + 1) && (c <= TO);
            check("stall", 32'(stall), 32'(memop && !mis && c < ret));
            check("dmem_req", 32'(dmem_req), 32'(exp_req));
            check("we6_bubble", 32'(we6), 32'd0);
            if (exp_req) begin
                check("dmem_addr", dmem_addr, a - (a % 4));
                check("dmem_be", 32'(dmem_be), bev);
                check("dmem_we", 32'(dmem_we), 32'(store));
                check("dmem_wdata", dmem_wdata, wd);
            end
            @(posedge clk); #1;
        end
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        check("we6", 32'(we6), 32'(exp_we));
        check("bus_err6", 32'(bus_err6), 32'(berr));
        check("misalign6", 32'(misalign6), 32'(mis));
        if (f && !memop) begin
            exp_wb = a; exp_rd = r; exp_known = 1'b1;
        end else if (memop && !mis && !berr && !store) begin
            exp_wb = ldv; exp_rd = r; exp_known = 1'b1;
        end else if (f) begin
            exp_known = 1'b0;
        end
        if (exp_known) begin
            check("wb_data6", wb_data6, exp_wb);
            check("rd6", 32'(rd6), 32'(exp_rd));
        end
        // R now holds a fn5=0 bubble: no request and no stall
        check("bubble_req", 32'(dmem_req), 32'd0);
        check("bubble_stall", 32'(stall), 32'd0);
        $display("[TB] op a=%08h fn=%0b rd=%0b wr=%0b mfn=%03b gd=%0d rdl=%0d nr=%0b ret=%0d wb=%08h we6=%0b berr=%0b mis=%0b",
                 a, f, mr, mw, mf, gd, rdl, noresp, ret, wb_data6, we6, bus_err6, misalign6);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b1;
        alu_res5 = '0; rd5 = '0; we5 = 1'b0; fn5 = 1'b0; mem_rd5 = 1'b0; mem_wr5 = 1'b0;
        mem_fn5 = '0; st_data5 = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_wb", wb_data6, 32'd0);
        check("rst_rd6", 32'(rd6), 32'd0);
        check("rst_we6", 32'(we6), 32'd0);
        check("rst_berr", 32'(bus_err6), 32'd0);
        check("rst_mis", 32'(misalign6), 32'd0);
        nrst = 1'b0;
        exp_wb = '0; exp_rd = '0; exp_known = 1'b1;

        // Directed cases
        run_op(32'h0000_1234, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 0, 1, 32'h0, 1'b0);
        run_op(32'h0000_0103, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0, 0, 3, 32'h80AA_BBCC, 1'b0);
        check("lb_value", wb_data6, 32'hFFFF_FF80);
        run_op(32'h0000_0103, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 32'h0, 0, 3, 32'h80AA_BBCC, 1'b0);
        check("lbu_value", wb_data6, 32'h0000_0080);
        run_op(32'h0000_0202, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_BEEF, 2, 1, 32'h0, 1'b0);
        run_op(32'h0000_0040, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0, 0, 1, 32'h0, 1'b1);
        run_op(32'h0000_5678, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 0, 1, 32'h0, 1'b0);
        run_op(32'h0000_0006, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0, 0, 1, 32'hCAFE_F00D, 1'b0);

        // Reset during WAIT_RSP discards the load; a late response is ignored
        alu_res5 = 32'h40; rd5 = 5'd3; we5 = 1'b1; fn5 = 1'b1; mem_rd5 = 1'b1; mem_wr5 = 1'b0;
        mem_fn5 = 3'b010; st_data5 = '0;
        @(posedge clk); #1;
        drive_bubble();
        dmem_gnt = 1'b1;
        @(negedge clk);
        check("mid_req", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        check("mid_wait_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b0;
        @(negedge clk);
        check("post_rst_req", 32'(dmem_req), 32'd0);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_we6", 32'(we6), 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        check("late_rvalid_we6", 32'(we6), 32'd0);
        check("late_rvalid_wb", wb_data6, 32'd0);
        check("late_rvalid_stall", 32'(stall), 32'd0);
        $display("[TB] reset during WAIT_RSP: req=%0b stall=%0b we6=%0b", dmem_req, stall, we6);
        exp_wb = '0; exp_rd = '0; exp_known = 1'b1;

        // Random ops with delays kept within the timeout, plus occasional missing responses
        for (int k = 0; k < 200; k++) begin
            ra    = $urandom;
            rr    = 5'($urandom);
            rw    = 1'($urandom);
            rf    = ($urandom_range(0, 7) != 0);
            rmr   = 1'($urandom);
            rmw   = 1'($urandom);
            rmf   = 3'($urandom);
            rst_d = $urandom;
            rgd   = $urandom_range(0, 2);
            rrl   = $urandom_range(1, 3);
            rdat  = $urandom;
            rnr   = ($urandom_range(0, 15) == 0);
            run_op(ra, rr, rw, rf, rmr, rmw, rmf, rst_d, rgd, rrl, rdat, rnr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
